// File: rtl/lane_transpose_commutator_if.sv
// Streaming bus for the 64x8 lane transpose: one beat of eight coefficients per cycle,
// plus the flush request that drains the pipeline.
interface lane_transpose_commutator_if #(
    parameter int DW    = 32,
    parameter int LANES = 8
);
    logic                valid_in;
    logic [LANES*DW-1:0] lane_in;
    logic                nttend;
    logic [LANES*DW-1:0] lane_out;
    logic                valid_out;

    modport master (
        output valid_in,
        output lane_in,
        output nttend,
        input  lane_out,
        input  valid_out
    );

    modport slave (
        input  valid_in,
        input  lane_in,
        input  nttend,
        output lane_out,
        output valid_out
    );
endinterface

// File: rtl/lane_transpose_commutator.sv
// 64x8 streaming transpose: lane j of output beat c carries element 64j+c of the frame.
// Two cascaded skew / commutator / deskew stages (stride 1, then stride 8), 63-advance latency.
module lane_transpose_commutator #(
    parameter int DW    = 32,
    parameter int LANES = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    lane_transpose_commutator_if.slave bus
);
    typedef logic [LANES-1:0][DW-1:0] beat_t;

    localparam int unsigned LATENCY = 63;

    logic               advance;
    logic [5:0]         beat_cnt;
    logic [2:0]         sel1;
    logic [2:0]         sel2;
    logic [LATENCY-1:0] vld_sr;

    beat_t x;
    beat_t a1;
    beat_t b1;
    beat_t c1;
    beat_t a2;
    beat_t b2;
    beat_t c2;

    assign advance = bus.valid_in | bus.nttend;
    assign x       = bus.lane_in;
    assign sel1    = beat_cnt[2:0];
    // Stage 2 consumes stage-1 output, which trails the input beat index by 7.
    assign sel2    = 3'((beat_cnt - 6'd7) >> 3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            vld_sr   <= '0;
        end else if (advance) begin
            beat_cnt <= beat_cnt + 6'd1;
            vld_sr   <= {vld_sr[LATENCY-2:0], bus.valid_in};
        end
    end

    always_comb begin
        b1 = '0;
        b2 = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            b1[j] = a1[3'(sel1 - 3'(j))];
            b2[j] = a2[3'(sel2 - 3'(j))];
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        localparam int unsigned D_SK1 = i;
        localparam int unsigned D_DS1 = LANES - 1 - i;
        localparam int unsigned D_SK2 = 8 * i;
        localparam int unsigned D_DS2 = 8 * (LANES - 1 - i);

        if (D_SK1 == 0) begin : g_sk1_wire
            assign a1[i] = x[i];
        end else begin : g_sk1
            typedef logic [D_SK1-1:0][DW-1:0] line_t;
            line_t sr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                end else if (advance) begin
                    sr <= line_t'({sr, x[i]});
                end
            end
            assign a1[i] = sr[D_SK1-1];
        end

        if (D_DS1 == 0) begin : g_ds1_wire
            assign c1[i] = b1[i];
        end else begin : g_ds1
            typedef logic [D_DS1-1:0][DW-1:0] line_t;
            line_t sr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                end else if (advance) begin
                    sr <= line_t'({sr, b1[i]});
                end
            end
            assign c1[i] = sr[D_DS1-1];
        end

        if (D_SK2 == 0) begin : g_sk2_wire
            assign a2[i] = c1[i];
        end else begin : g_sk2
            typedef logic [D_SK2-1:0][DW-1:0] line_t;
            line_t sr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                end else if (advance) begin
                    sr <= line_t'({sr, c1[i]});
                end
            end
            assign a2[i] = sr[D_SK2-1];
        end

        if (D_DS2 == 0) begin : g_ds2_wire
            assign c2[i] = b2[i];
        end else begin : g_ds2
            typedef logic [D_DS2-1:0][DW-1:0] line_t;
            line_t sr;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sr <= '0;
                end else if (advance) begin
                    sr <= line_t'({sr, b2[i]});
                end
            end
            assign c2[i] = sr[D_DS2-1];
        end
    end

    // Outputs move only on advance; a stalled cycle drops valid but keeps the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.valid_out <= 1'b0;
            bus.lane_out  <= '0;
        end else if (advance) begin
            bus.valid_out <= vld_sr[LATENCY-1];
            bus.lane_out  <= c2;
        end else begin
            bus.valid_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lane_transpose_commutator.sv
// Bench for lane_transpose_commutator: element-numbering reference model over a beat history.
module tb_lane_transpose_commutator;
    localparam int DW    = 32;
    localparam int LANES = 8;
    typedef logic [LANES*DW-1:0] beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lane_transpose_commutator_if #(.DW(DW), .LANES(LANES)) bus ();
    lane_transpose_commutator #(.DW(DW), .LANES(LANES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t hist_d [$];
    bit    hist_v [$];
    bit    adv;
    bit    exp_v;
    bit    exp_known;
    beat_t exp_d;
    beat_t prev_out;

    function automatic beat_t seq_beat(input int t);
        beat_t b;
        for (int i = 0; i < LANES; i++) b[i*DW +: DW] = DW'(8 * t + i);
        return b;
    endfunction

    function automatic beat_t column_beat(input int base);
        beat_t b;
        for (int j = 0; j < LANES; j++) b[j*DW +: DW] = DW'(base + 64 * j);
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        for (int i = 0; i < LANES; i++) b[i*DW +: DW] = $urandom;
        return b;
    endfunction

    // Output beat q (counted over all advances) is frame q/64, beat c = q%64; lane j
    // holds element 64j+c, i.e. input beat (64j+c)/8, lane (64j+c)%8 of that frame.
    function automatic bit expected_beat(input int q, output beat_t d);
        int f     = q / 64;
        int c     = q % 64;
        bit known = 1'b1;
        d = '0;
        for (int j = 0; j < LANES; j++) begin
            int    n   = 64 * j + c;
            int    t   = f * 64 + n / 8;
            beat_t src = hist_d[t];
            d[j*DW +: DW] = src[(n % 8)*DW +: DW];
            if (!hist_v[t]) known = 1'b0;
        end
        return known;
    endfunction

    task automatic step(input bit v, input bit n, input beat_t d);
        int k;
        prev_out     = bus.lane_out;
        bus.valid_in = v;
        bus.nttend   = n;
        bus.lane_in  = d;
        @(posedge clk);
        adv       = v | n;
        exp_v     = 1'b0;
        exp_known = 1'b0;
        exp_d     = '0;
        if (adv) begin
            hist_d.push_back(d);
            hist_v.push_back(v);
            k = hist_d.size() - 1;
            if (k >= 63) begin
                exp_v     = hist_v[k-63];
                exp_known = expected_beat(k - 63, exp_d);
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.valid_in = 1'b0;
        bus.nttend   = 1'b0;
        bus.lane_in  = '0;
        hist_d.delete();
        hist_v.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.valid_out !== 1'b0 || bus.lane_out !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got valid=%b data=%h expected 0/0", bus.valid_out, bus.lane_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, rand_beat());
            n_checks++;
            if (bus.valid_out !== 1'b0 || bus.lane_out !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cyc %0d: got valid=%b data=%h expected 0/0", i, bus.valid_out, bus.lane_out);
            end
        end
    endtask

    task automatic test_contiguous();
        int vcount = 0;
        do_reset();
        for (int i = 0; i < 127; i++) begin
            if (i < 64) step(1'b1, 1'b0, seq_beat(i));
            else        step(1'b0, 1'b1, rand_beat());
            n_checks++;
            if (bus.valid_out !== exp_v) begin
                n_fail++;
                $display("FAIL contig_valid cyc %0d: got %b expected %b", i, bus.valid_out, exp_v);
            end
            if (exp_v && exp_known) begin
                n_checks++;
                if (bus.lane_out !== exp_d) begin
                    n_fail++;
                    $display("FAIL contig_data cyc %0d: got %h expected %h", i, bus.lane_out, exp_d);
                end
            end
            if (i == 63 || i == 126) begin
                n_checks++;
                if (bus.lane_out !== column_beat(i - 63)) begin
                    n_fail++;
                    $display("FAIL contig_edge_beat cyc %0d: got %h expected %h", i, bus.lane_out, column_beat(i - 63));
                end
            end
            if (bus.valid_out === 1'b1) vcount++;
        end
        n_checks++;
        if (vcount != 64) begin
            n_fail++;
            $display("FAIL contig_valid_count: got %0d expected 64", vcount);
        end
    endtask

    task automatic test_gapped();
        int beats  = 0;
        int vcount = 0;
        do_reset();
        for (int i = 0; i < 381; i++) begin
            if (i % 3 == 0) begin
                if (beats < 64) begin
                    step(1'b1, 1'b0, seq_beat(beats));
                    beats++;
                end else begin
                    step(1'b0, 1'b1, rand_beat());
                end
            end else begin
                step(1'b0, 1'b0, rand_beat());
            end
            n_checks++;
            if (bus.valid_out !== exp_v) begin
                n_fail++;
                $display("FAIL gapped_valid cyc %0d: got %b expected %b", i, bus.valid_out, exp_v);
            end
            if (exp_v && exp_known) begin
                n_checks++;
                if (bus.lane_out !== exp_d) begin
                    n_fail++;
                    $display("FAIL gapped_data cyc %0d: got %h expected %h", i, bus.lane_out, exp_d);
                end
            end else if (!adv) begin
                n_checks++;
                if (bus.lane_out !== prev_out) begin
                    n_fail++;
                    $display("FAIL gapped_hold cyc %0d: got %h expected %h", i, bus.lane_out, prev_out);
                end
            end
            if (bus.valid_out === 1'b1) vcount++;
        end
        n_checks++;
        if (vcount != 64) begin
            n_fail++;
            $display("FAIL gapped_valid_count: got %0d expected 64", vcount);
        end
    endtask

    task automatic test_back_to_back();
        int vcount = 0;
        int first  = -1;
        int last   = -1;
        do_reset();
        for (int i = 0; i < 191; i++) begin
            if (i < 128) step(1'b1, 1'b0, seq_beat(i));
            else         step(1'b0, 1'b1, rand_beat());
            n_checks++;
            if (bus.valid_out !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_valid cyc %0d: got %b expected %b", i, bus.valid_out, exp_v);
            end
            if (exp_v && exp_known) begin
                n_checks++;
                if (bus.lane_out !== exp_d) begin
                    n_fail++;
                    $display("FAIL b2b_data cyc %0d: got %h expected %h", i, bus.lane_out, exp_d);
                end
            end
            if (i == 127) begin
                n_checks++;
                if (bus.lane_out !== column_beat(512)) begin
                    n_fail++;
                    $display("FAIL b2b_frame1_first: got %h expected %h", bus.lane_out, column_beat(512));
                end
            end
            if (bus.valid_out === 1'b1) begin
                vcount++;
                if (first < 0) first = i;
                last = i;
            end
        end
        n_checks++;
        if (vcount != 128 || last - first + 1 != 128) begin
            n_fail++;
            $display("FAIL b2b_no_gap: got count=%0d span=%0d expected 128/128", vcount, last - first + 1);
        end
    endtask

    task automatic test_reset_mid_frame();
        int vcount = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, seq_beat(i));
            n_checks++;
            if (bus.valid_out !== exp_v) begin
                n_fail++;
                $display("FAIL midrst_pre_valid cyc %0d: got %b expected %b", i, bus.valid_out, exp_v);
            end
        end
        #2 rst_n = 1'b0;
        bus.valid_in = 1'b1;
        bus.lane_in  = rand_beat();
        #1;
        n_checks++;
        if (bus.valid_out !== 1'b0 || bus.lane_out !== '0) begin
            n_fail++;
            $display("FAIL midrst_async: got valid=%b data=%h expected 0/0", bus.valid_out, bus.lane_out);
        end
        hist_d.delete();
        hist_v.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.valid_out !== 1'b0 || bus.lane_out !== '0) begin
                n_fail++;
                $display("FAIL midrst_hold cyc %0d: got valid=%b data=%h expected 0/0", i, bus.valid_out, bus.lane_out);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 127; i++) begin
            if (i < 64) step(1'b1, 1'b0, seq_beat(i));
            else        step(1'b0, 1'b1, rand_beat());
            n_checks++;
            if (bus.valid_out !== exp_v) begin
                n_fail++;
                $display("FAIL midrst_valid cyc %0d: got %b expected %b", i, bus.valid_out, exp_v);
            end
            if (exp_v && exp_known) begin
                n_checks++;
                if (bus.lane_out !== exp_d) begin
                    n_fail++;
                    $display("FAIL midrst_data cyc %0d: got %h expected %h", i, bus.lane_out, exp_d);
                end
            end
            if (bus.valid_out === 1'b1) vcount++;
        end
        n_checks++;
        if (vcount != 64) begin
            n_fail++;
            $display("FAIL midrst_valid_count: got %0d expected 64", vcount);
        end
    endtask

    task automatic test_idle_hold();
        int  beats = 0;
        bit  idle;
        do_reset();
        for (int i = 0; i < 147; i++) begin
            idle = (i >= 30 && i < 40) || (i >= 100 && i < 110);
            if (idle) begin
                step(1'b0, 1'b0, rand_beat());
            end else if (beats < 64) begin
                step(1'b1, 1'b0, rand_beat());
                beats++;
            end else begin
                step(1'b0, 1'b1, rand_beat());
            end
            n_checks++;
            if (bus.valid_out !== exp_v) begin
                n_fail++;
                $display("FAIL idle_valid cyc %0d: got %b expected %b", i, bus.valid_out, exp_v);
            end
            if (exp_v && exp_known) begin
                n_checks++;
                if (bus.lane_out !== exp_d) begin
                    n_fail++;
                    $display("FAIL idle_data cyc %0d: got %h expected %h", i, bus.lane_out, exp_d);
                end
            end else if (!adv) begin
                n_checks++;
                if (bus.lane_out !== prev_out) begin
                    n_fail++;
                    $display("FAIL idle_hold cyc %0d: got %h expected %h", i, bus.lane_out, prev_out);
                end
            end
        end
    endtask

    task automatic test_valid_and_nttend();
        do_reset();
        for (int i = 0; i < 127; i++) begin
            if (i < 64) step(1'b1, 1'b1, rand_beat());
            else        step(1'b0, 1'b1, rand_beat());
            n_checks++;
            if (bus.valid_out !== exp_v) begin
                n_fail++;
                $display("FAIL both_valid cyc %0d: got %b expected %b", i, bus.valid_out, exp_v);
            end
            if (exp_v && exp_known) begin
                n_checks++;
                if (bus.lane_out !== exp_d) begin
                    n_fail++;
                    $display("FAIL both_data cyc %0d: got %h expected %h", i, bus.lane_out, exp_d);
                end
            end
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if (i >= 500) step(1'b0, 1'b1, rand_beat());
            else          step(r < 5, r >= 3 && r < 8, rand_beat());
            n_checks++;
            if (bus.valid_out !== exp_v) begin
                n_fail++;
                $display("FAIL rand_valid cyc %0d: got %b expected %b", i, bus.valid_out, exp_v);
            end
            if (exp_v && exp_known) begin
                n_checks++;
                if (bus.lane_out !== exp_d) begin
                    n_fail++;
                    $display("FAIL rand_data cyc %0d: got %h expected %h", i, bus.lane_out, exp_d);
                end
            end else if (!adv) begin
                n_checks++;
                if (bus.lane_out !== prev_out) begin
                    n_fail++;
                    $display("FAIL rand_hold cyc %0d: got %h expected %h", i, bus.lane_out, prev_out);
                end
            end
        end
    endtask

    initial begin
        bus.valid_in = 1'b0;
        bus.nttend   = 1'b0;
        bus.lane_in  = '0;
        test_reset();
        test_contiguous();
        test_gapped();
        test_back_to_back();
        test_reset_mid_frame();
        test_idle_hold();
        test_valid_and_nttend();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
